// File: rtl/fx2_out_spi_tx.sv
// fx2_out_spi_tx: drains 16-bit words from the FX2 OUT endpoint over the
// synchronous slave-FIFO interface into a small circular buffer, then
// serializes them MSB-first onto TX_CLK/TX_DATA/TX_LOAD/TX_STOP.
// The FD bus is shared with the slave-FIFO writer via BUS_REQ/BUS_GNT.
// Optional feature macro: SPI_TX_PARITY_EN appends an odd-parity bit after
// bit 0 of every word (18 TX_CLK periods per word instead of 17).
module fx2_out_spi_tx #(
  parameter logic [1:0] OUT_EP_ADR = 2'b00,
  parameter int         BUF_DEPTH  = 16,
  parameter int         CLK_DIV    = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLAG_EMPTY,
  input  logic [15:0]                FD_IN,
  input  logic                       BUS_GNT,
  output logic                       BUS_REQ,
  output logic                       SLOE,
  output logic                       SLRD,
  output logic [1:0]                 FIFOADR,
  output logic                       TX_CLK,
  output logic                       TX_DATA,
  output logic                       TX_LOAD,
  output logic                       TX_STOP,
  output logic [$clog2(BUF_DEPTH):0] BUF_LEVEL
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef SPI_TX_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam int BW = $clog2(NB);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(BUF_DEPTH);

  typedef enum logic [2:0] {RD_IDLE, RD_WAIT_GNT, RD_OE, RD_READ, RD_GAP} rd_state_t;
  typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_LOAD} ser_state_t;

  rd_state_t     r_rd_state;
  logic          r_bus_req;
  logic          r_sloe;
  logic          r_slrd;
  logic          r_gap;

  logic [15:0]   r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;

  ser_state_t    r_ser_state;
  logic [NB-1:0] r_shift;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic          r_tx_clk;
  logic          r_tx_data;
  logic          r_tx_load;
  logic          r_tx_stop;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_level_next;
  logic [15:0]   w_pop_word;
  logic [NB-1:0] w_frame;
  logic          w_half_end;
  logic          w_word_end;

  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  // A word is captured only in the READ cycle and only while still granted.
  assign w_push     = (r_rd_state == RD_READ) && BUS_GNT;
  assign w_half_end = (r_div == DIV_LAST);
  assign w_word_end = (r_ser_state == SER_LOAD) && r_tx_clk && w_half_end;
  // Pop from IDLE, or straight out of LOAD so consecutive words have no gap.
  assign w_pop      = !w_empty && ((r_ser_state == SER_IDLE) || w_word_end);
  assign w_pop_word = r_mem[r_rptr];
`ifdef SPI_TX_PARITY_EN
  assign w_frame    = {w_pop_word, ~^w_pop_word};
`else
  assign w_frame    = w_pop_word;
`endif

  // Strobes are forced inactive the moment the grant is lost.
  assign SLOE      = r_sloe | ~BUS_GNT;
  assign SLRD      = r_slrd | ~BUS_GNT;
  assign BUS_REQ   = r_bus_req;
  assign FIFOADR   = OUT_EP_ADR;
  assign TX_CLK    = r_tx_clk;
  assign TX_DATA   = r_tx_data;
  assign TX_LOAD   = r_tx_load;
  assign TX_STOP   = r_tx_stop;
  assign BUF_LEVEL = r_level;

  // Next buffer occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop)      w_level_next = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_next = r_level - 1'b1;
  end

  // Reader FSM: bus request, OE, one-cycle read strobe, two-cycle flag settle gap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_state <= RD_IDLE;
      r_bus_req  <= 1'b0;
      r_sloe     <= 1'b1;
      r_slrd     <= 1'b1;
      r_gap      <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (FLAG_EMPTY && !w_full) begin
            r_bus_req  <= 1'b1;
            r_rd_state <= RD_WAIT_GNT;
          end
        end
        RD_WAIT_GNT: begin
          if (BUS_GNT) begin
            r_sloe     <= 1'b0;
            r_rd_state <= RD_OE;
          end
        end
        RD_OE: begin
          if (BUS_GNT) begin
            r_slrd     <= 1'b0;
            r_rd_state <= RD_READ;
          end else begin
            r_sloe     <= 1'b1;
            r_bus_req  <= 1'b0;
            r_rd_state <= RD_IDLE;
          end
        end
        RD_READ: begin
          r_sloe <= 1'b1;
          r_slrd <= 1'b1;
          r_gap  <= 1'b0;
          if (BUS_GNT) begin
            r_rd_state <= RD_GAP;
          end else begin
            r_bus_req  <= 1'b0;
            r_rd_state <= RD_IDLE;
          end
        end
        RD_GAP: begin
          if (!r_gap) begin
            r_gap <= 1'b1;
          end else if (FLAG_EMPTY && !w_full && BUS_GNT) begin
            r_sloe     <= 1'b0;
            r_rd_state <= RD_OE;
          end else begin
            r_bus_req  <= 1'b0;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  // Buffer storage: data only, no reset needed.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= FD_IN;
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_next;
    end
  end

  // Serializer FSM: CLK_DIV low then CLK_DIV high per bit, data moves on the falling edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ser_state <= SER_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_tx_clk    <= 1'b0;
      r_tx_data   <= 1'b0;
      r_tx_load   <= 1'b0;
      r_tx_stop   <= 1'b0;
    end else if (w_pop) begin
      r_shift     <= w_frame;
      r_tx_data   <= w_frame[NB-1];
      r_tx_clk    <= 1'b0;
      r_tx_load   <= 1'b0;
      r_tx_stop   <= 1'b0;
      r_div       <= '0;
      r_bit       <= '0;
      r_ser_state <= SER_SHIFT;
    end else begin
      case (r_ser_state)
        SER_SHIFT: begin
          if (!w_half_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_tx_clk) begin
              r_tx_clk <= 1'b1;
            end else begin
              r_tx_clk <= 1'b0;
              if (r_bit == BIT_LAST) begin
                r_tx_data   <= 1'b0;
                r_tx_load   <= 1'b1;
                r_tx_stop   <= (w_level_next == '0);
                r_ser_state <= SER_LOAD;
              end else begin
                r_bit     <= r_bit + 1'b1;
                r_shift   <= r_shift << 1;
                r_tx_data <= r_shift[NB-2];
              end
            end
          end
        end
        SER_LOAD: begin
          if (!w_half_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_tx_clk) begin
              r_tx_clk <= 1'b1;
            end else begin
              r_tx_clk    <= 1'b0;
              r_tx_load   <= 1'b0;
              r_tx_stop   <= 1'b0;
              r_ser_state <= SER_IDLE;
            end
          end
        end
        SER_IDLE: ;
        default: r_ser_state <= SER_IDLE;
      endcase
    end
  end
endmodule
